// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit byte FIFO between bus write side and uart_controller
//
// Purpose:
//   Buffers bytes written by the bus and presents the head entry
//   first-word-fall-through on data_o. load_o is ~empty. A single-cycle
//   pull_i pulse from the controller pops the head entry.
//
// Optional feature macro: UART_TX_FIFO_STATUS_EN
//   When defined, the level_o and overflow_o ports and the sticky overflow
//   flag are added. Everything else behaves the same in both builds.
//
// Ports:
//   clk_i       in   1              clock, rising edge
//   rst_i       in   1              synchronous reset, active-high
//   flush_i     in   1              synchronous discard of all entries
//   wr_en_i     in   1              enqueue strobe, one entry per cycle
//   wr_data_i   in   DATA_UART      byte to enqueue
//   pull_i      in   1              pop head entry
//   data_o      out  DATA_UART      head entry, valid while load_o=1
//   load_o      out  1              FIFO not empty
//   full_o      out  1              FIFO holds DEPTH entries
//   empty_o     out  1              FIFO holds no entries
//   level_o     out  DEPTH_LOG2+1   entry count          (status build only)
//   overflow_o  out  1              sticky write-on-full (status build only)

module uart_tx_fifo #(
  parameter int DATA_UART  = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DATA_UART-1:0]  wr_data_i,
  input  logic                  pull_i,
  output logic [DATA_UART-1:0]  data_o,
  output logic                  load_o,
  output logic                  full_o,
  output logic                  empty_o
`ifdef UART_TX_FIFO_STATUS_EN
  ,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  overflow_o
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the index bits match.
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic [DATA_UART-1:0]  mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  empty;
  logic                  full;
  logic                  do_wr;
  logic                  do_rd;

  assign wr_idx = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_idx = rd_ptr[DEPTH_LOG2-1:0];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_idx == rd_idx) && (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);

  // A pop on an empty FIFO is ignored, which also covers write+pull into an
  // empty FIFO: the write lands, the pull does nothing.
  assign do_wr = wr_en_i & ~full;
  assign do_rd = pull_i & ~empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // Clearing the slot the head reads from makes data_o read zero after reset.
      mem[0] <= '0;
    end else if (flush_i) begin
      // Discard by catching the read pointer up; any write or pop this cycle is dropped.
      rd_ptr <= wr_ptr;
    end else begin
      if (do_wr) begin
        mem[wr_idx] <= wr_data_i;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // All outputs are functions of registered state only.
  assign data_o  = mem[rd_idx];
  assign load_o  = ~empty;
  assign full_o  = full;
  assign empty_o = empty;

`ifdef UART_TX_FIFO_STATUS_EN
  logic overflow_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      overflow_q <= 1'b0;
    end else if (wr_en_i && full) begin
      overflow_q <= 1'b1;
    end
  end

  // Modulo-2*DEPTH difference of the wrap-extended pointers is the entry count.
  assign level_o    = wr_ptr - rd_ptr;
  assign overflow_o = overflow_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo

module tb_uart_tx_fifo;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       wr_en_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       pull_i = 1'b0;
  logic [7:0] data_o;
  logic       load_o;
  logic       full_o;
  logic       empty_o;
`ifdef UART_TX_FIFO_STATUS_EN
  logic [4:0] level_o;
  logic       overflow_o;
`endif

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(.DATA_UART(8), .DEPTH_LOG2(4)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .wr_en_i   (wr_en_i),
    .wr_data_i (wr_data_i),
    .pull_i    (pull_i),
    .data_o    (data_o),
    .load_o    (load_o),
    .full_o    (full_o),
    .empty_o   (empty_o)
`ifdef UART_TX_FIFO_STATUS_EN
    ,
    .level_o   (level_o),
    .overflow_o(overflow_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
    checks++; if (load_o !== 1'b0) begin errors++; $display("FAIL reset_load got=%b exp=0", load_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data_o); end
`ifdef UART_TX_FIFO_STATUS_EN
    checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
`endif
  endtask

  task automatic test_basic();
    wr_en_i = 1'b1; wr_data_i = 8'hA5;
    step();
    checks++; if (load_o !== 1'b1) begin errors++; $display("FAIL basic_load got=%b exp=1", load_o); end
    checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL basic_first got=%h exp=a5", data_o); end
    wr_data_i = 8'h3C;
    step();
    wr_en_i = 1'b0;
    checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL basic_hold got=%h exp=a5", data_o); end
    pull_i = 1'b1;
    step();
    pull_i = 1'b0;
    checks++; if (data_o !== 8'h3C) begin errors++; $display("FAIL basic_second got=%h exp=3c", data_o); end
    pull_i = 1'b1;
    step();
    pull_i = 1'b0;
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL basic_empty got=%b exp=1", empty_o); end
    checks++; if (load_o !== 1'b0) begin errors++; $display("FAIL basic_load_end got=%b exp=0", load_o); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wr_en_i = 1'b1; wr_data_i = 8'(i);
      step();
      if (i == 14) begin
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL fill_not_full15 got=%b exp=0", full_o); end
      end
    end
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full_o); end
    wr_data_i = 8'hFF;
    step();
    wr_en_i = 1'b0;
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_drop_full got=%b exp=1", full_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL fill_drop_head got=%h exp=00", data_o); end
`ifdef UART_TX_FIFO_STATUS_EN
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL fill_overflow got=%b exp=1", overflow_o); end
    checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL fill_level got=%0d exp=16", level_o); end
`endif
    for (int i = 0; i < 16; i++) begin
      checks++; if (data_o !== 8'(i)) begin errors++; $display("FAIL fill_drain[%0d] got=%h exp=%h", i, data_o, 8'(i)); end
      pull_i = 1'b1;
      step();
      pull_i = 1'b0;
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL fill_drained_empty got=%b exp=1", empty_o); end
`ifdef UART_TX_FIFO_STATUS_EN
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL fill_overflow_sticky got=%b exp=1", overflow_o); end
`endif
  endtask

  task automatic test_write_pull_empty();
    wr_en_i = 1'b1; wr_data_i = 8'h77; pull_i = 1'b1;
    step();
    wr_en_i = 1'b0; pull_i = 1'b0;
    checks++; if (load_o !== 1'b1) begin errors++; $display("FAIL wpe_load got=%b exp=1", load_o); end
    checks++; if (data_o !== 8'h77) begin errors++; $display("FAIL wpe_data got=%h exp=77", data_o); end
    pull_i = 1'b1;
    step();
    pull_i = 1'b0;
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL wpe_empty got=%b exp=1", empty_o); end
  endtask

  task automatic test_concurrent();
    logic [7:0] q[$];
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
`ifdef UART_TX_FIFO_STATUS_EN
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL conc_flush_ovf got=%b exp=0", overflow_o); end
`endif
    for (int i = 0; i < 3; i++) begin
      wr_en_i = 1'b1; wr_data_i = 8'h10 + 8'(i);
      q.push_back(8'h10 + 8'(i));
      step();
    end
    for (int i = 0; i < 40; i++) begin
      checks++; if (data_o !== q[0]) begin errors++; $display("FAIL conc_head[%0d] got=%h exp=%h", i, data_o, q[0]); end
      wr_en_i = 1'b1; wr_data_i = 8'h40 + 8'(i); pull_i = 1'b1;
      step();
      void'(q.pop_front());
      q.push_back(8'h40 + 8'(i));
`ifdef UART_TX_FIFO_STATUS_EN
      checks++; if (level_o !== 5'd3) begin errors++; $display("FAIL conc_level[%0d] got=%0d exp=3", i, level_o); end
`endif
    end
    wr_en_i = 1'b0; pull_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (data_o !== q[0]) begin errors++; $display("FAIL conc_tail[%0d] got=%h exp=%h", i, data_o, q[0]); end
      pull_i = 1'b1;
      step();
      pull_i = 1'b0;
      void'(q.pop_front());
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL conc_empty got=%b exp=1", empty_o); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      wr_en_i = 1'b1; wr_data_i = 8'hB0 + 8'(i);
      step();
    end
    flush_i = 1'b1; wr_en_i = 1'b1; wr_data_i = 8'hEE; pull_i = 1'b1;
    step();
    flush_i = 1'b0; wr_en_i = 1'b0;
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b exp=1", empty_o); end
`ifdef UART_TX_FIFO_STATUS_EN
    checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL flush_level got=%0d exp=0", level_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL flush_overflow got=%b exp=0", overflow_o); end
`endif
    // Pull held into the cycle after flush must be ignored.
    step();
    pull_i = 1'b0;
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL flush_pull_after got=%b exp=1", empty_o); end
    wr_en_i = 1'b1; wr_data_i = 8'h5A;
    step();
    wr_en_i = 1'b0;
    checks++; if (data_o !== 8'h5A) begin errors++; $display("FAIL flush_rewrite got=%h exp=5a", data_o); end
`ifdef UART_TX_FIFO_STATUS_EN
    checks++; if (level_o !== 5'd1) begin errors++; $display("FAIL flush_rewrite_level got=%0d exp=1", level_o); end
`endif
    pull_i = 1'b1;
    step();
    pull_i = 1'b0;
  endtask

  // Controller-style consumer: sample data_o while load_o=1, pull one cycle later.
  task automatic test_handshake();
    logic [7:0] exp_bytes [3];
    int got;
    int pulls;
    logic [7:0] sampled;
    exp_bytes[0] = 8'h55; exp_bytes[1] = 8'hAA; exp_bytes[2] = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      wr_en_i = 1'b1; wr_data_i = exp_bytes[i];
      step();
    end
    wr_en_i = 1'b0;
    got = 0;
    pulls = 0;
    for (int cyc = 0; cyc < 100 && got < 3; cyc++) begin
      if (load_o) begin
        sampled = data_o;
        checks++; if (sampled !== exp_bytes[got]) begin errors++; $display("FAIL hs_byte[%0d] got=%h exp=%h", got, sampled, exp_bytes[got]); end
        step();
        checks++; if (data_o !== sampled) begin errors++; $display("FAIL hs_stable[%0d] got=%h exp=%h", got, data_o, sampled); end
        pull_i = 1'b1;
        step();
        pull_i = 1'b0;
        pulls++;
        got++;
      end else begin
        step();
      end
    end
    checks++; if (got !== 3) begin errors++; $display("FAIL hs_timeout got=%0d exp=3", got); end
    checks++; if (pulls !== 3) begin errors++; $display("FAIL hs_pulls got=%0d exp=3", pulls); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL hs_empty got=%b exp=1", empty_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_write_pull_empty();
    test_concurrent();
    test_flush();
    test_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
